keypad_entry_ctrl: RTL and testbench

- Sequences the two-digit BCD shift/load register from debounced keypad events.
- Turns key pulses into load_d/load_u/rdy strobes and the digit bus, for two operands (A then B).
- Issues a start pulse to the downstream arithmetic unit once both operands are confirmed.
- Sits between the keypad scanner/debouncer and the digit-capture register.

---
 rtl/keypad_entry_ctrl_if.sv | 35 +++
 rtl/keypad_entry_ctrl.sv | 156 +++++++++++++++
 tb/tb_keypad_entry_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/keypad_entry_ctrl_if.sv
// Keypad event / digit-register strobe bundle for keypad_entry_ctrl.
// entry_err is present only when ENTRY_ERR_EN is defined.
interface keypad_entry_ctrl_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       busy_i;
  logic       load_d;
  logic       load_u;
  logic       rdy;
  logic [3:0] tecla_d;
  logic       op_sel;
  logic       start;
  logic       timeout;
`ifdef ENTRY_ERR_EN
  logic       entry_err;

  modport master (
    output key_valid, key_code, busy_i,
    input  load_d, load_u, rdy, tecla_d, op_sel, start, timeout, entry_err
  );
  modport slave (
    input  key_valid, key_code, busy_i,
    output load_d, load_u, rdy, tecla_d, op_sel, start, timeout, entry_err
  );
`else
  modport master (
    output key_valid, key_code, busy_i,
    input  load_d, load_u, rdy, tecla_d, op_sel, start, timeout
  );
  modport slave (
    input  key_valid, key_code, busy_i,
    output load_d, load_u, rdy, tecla_d, op_sel, start, timeout
  );
`endif
endinterface

// File: rtl/keypad_entry_ctrl.sv
// Two-operand keypad entry sequencer: turns key pulses into digit-register strobes and a start pulse.
// Optional ENTRY_ERR_EN macro adds the entry_err pulse output.
module keypad_entry_ctrl #(
  parameter int TIMEOUT_CYCLES = 27_000_000
) (
  input  logic                clk,
  input  logic                rst,
  keypad_entry_ctrl_if.slave  kp,
  output logic [1:0]          state_dbg
);
  localparam int CW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W = (CW < 1) ? 1 : CW;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    WAIT_D     = 2'd0,
    WAIT_U     = 2'd1,
    WAIT_ENT   = 2'd2,
    START_WAIT = 2'd3
  } state_t;

  // key_valid is a one-cycle pulse with no back-pressure: every pulse is consumed
  // in the cycle it is sampled, and its response appears on the registered outputs next cycle.
  state_t           state, state_nx;
  logic             op_sel_q, op_sel_nx;
  logic [3:0]       tecla_q, tecla_nx;
  logic             load_d_q, load_d_nx;
  logic             load_u_q, load_u_nx;
  logic             rdy_q, rdy_nx;
  logic             start_q, start_nx;
  logic             timeout_q, timeout_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             is_digit, is_clear, is_enter, is_other, count_en;

  assign is_digit = kp.key_valid && (kp.key_code <= 4'd9);
  assign is_clear = kp.key_valid && (kp.key_code == 4'hE);
  assign is_enter = kp.key_valid && (kp.key_code == 4'hF);
  assign is_other = kp.key_valid && !is_digit && !is_clear && !is_enter;

  // Inactivity only matters once an entry is under way (a digit pending or operand B selected).
  assign count_en = (TIMEOUT_CYCLES != 0) && (state != START_WAIT) &&
                    ((state == WAIT_U) || (state == WAIT_ENT) || op_sel_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= WAIT_D;
      op_sel_q  <= 1'b0;
      tecla_q   <= 4'd0;
      load_d_q  <= 1'b0;
      load_u_q  <= 1'b0;
      rdy_q     <= 1'b0;
      start_q   <= 1'b0;
      timeout_q <= 1'b0;
      cnt       <= '0;
    end else begin
      state     <= state_nx;
      op_sel_q  <= op_sel_nx;
      tecla_q   <= tecla_nx;
      load_d_q  <= load_d_nx;
      load_u_q  <= load_u_nx;
      rdy_q     <= rdy_nx;
      start_q   <= start_nx;
      timeout_q <= timeout_nx;
      cnt       <= cnt_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    op_sel_nx  = op_sel_q;
    tecla_nx   = tecla_q;
    load_d_nx  = 1'b0;
    load_u_nx  = 1'b0;
    rdy_nx     = 1'b0;
    start_nx   = 1'b0;
    timeout_nx = 1'b0;
    cnt_nx     = '0;

    case (state)
      WAIT_D: begin
        if (is_digit) begin
          load_d_nx = 1'b1;
          tecla_nx  = kp.key_code;
          state_nx  = WAIT_U;
        end
      end
      WAIT_U: begin
        if (is_digit) begin
          load_u_nx = 1'b1;
          tecla_nx  = kp.key_code;
          state_nx  = WAIT_ENT;
        end else if (is_clear) begin
          op_sel_nx = 1'b0;
          state_nx  = WAIT_D;
        end
      end
      WAIT_ENT: begin
        if (is_enter) begin
          rdy_nx = 1'b1;
          if (op_sel_q) begin
            state_nx = START_WAIT;
          end else begin
            op_sel_nx = 1'b1;
            state_nx  = WAIT_D;
          end
        end else if (is_clear) begin
          op_sel_nx = 1'b0;
          state_nx  = WAIT_D;
        end
      end
      START_WAIT: begin
        if (!kp.busy_i) begin
          start_nx  = 1'b1;
          op_sel_nx = 1'b0;
          state_nx  = WAIT_D;
        end
      end
      default: state_nx = WAIT_D;
    endcase

    // A key arriving on the expiry cycle wins: the counter simply restarts.
    if (count_en && !kp.key_valid && (state_nx == state)) begin
      if (cnt == CNT_LAST) begin
        timeout_nx = 1'b1;
        op_sel_nx  = 1'b0;
        state_nx   = WAIT_D;
      end else begin
        cnt_nx = cnt + 1'b1;
      end
    end
  end

  assign kp.load_d  = load_d_q;
  assign kp.load_u  = load_u_q;
  assign kp.rdy     = rdy_q;
  assign kp.start   = start_q;
  assign kp.timeout = timeout_q;
  assign kp.tecla_d = tecla_q;
  assign kp.op_sel  = op_sel_q;
  assign state_dbg  = state;

`ifdef ENTRY_ERR_EN
  logic err_q, err_nx;

  assign err_nx = (is_other && (state != START_WAIT)) ||
                  (is_enter && (state == WAIT_U)) ||
                  (is_digit && (state == WAIT_ENT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_nx;
  end

  assign kp.entry_err = err_q;
`endif
endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Self-checking bench for keypad_entry_ctrl: directed key sequences, a cycle-level
// reference model compared every cycle, and hand-computed literal checks.
`timescale 1ns/1ps
module tb_keypad_entry_ctrl;
  localparam int T = 20;
`ifdef ENTRY_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  // clock / reset
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] state_dbg;
  always #5 clk = ~clk;

  keypad_entry_ctrl_if kp();

  keypad_entry_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk       (clk),
    .rst       (rst),
    .kp        (kp),
    .state_dbg (state_dbg)
  );

  logic dut_err;
`ifdef ENTRY_ERR_EN
  assign dut_err = kp.entry_err;
`else
  assign dut_err = 1'b0;
`endif

  int vectors     = 0;
  int miscompares = 0;

  // reference model: digits collected for the current operand, operand index,
  // whether a launch is pending, and cycles since the last activity
  int         m_digits  = 0;
  bit         m_operand = 1'b0;
  bit         m_launch  = 1'b0;
  int         m_idle    = 0;
  logic [3:0] m_tecla   = 4'd0;
  logic e_load_d = 0, e_load_u = 0, e_rdy = 0, e_start = 0, e_timeout = 0, e_err = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_digits = 0; m_operand = 0; m_launch = 0; m_idle = 0; m_tecla = 4'd0;
      e_load_d = 0; e_load_u = 0; e_rdy = 0; e_start = 0; e_timeout = 0; e_err = 0;
    end else begin
      bit         active;
      bit         kv;
      logic [3:0] kc;
      kv = kp.key_valid;
      kc = kp.key_code;
      active = ((m_digits != 0) || m_operand) && !m_launch;
      e_load_d = 0; e_load_u = 0; e_rdy = 0; e_start = 0; e_timeout = 0; e_err = 0;
      if (m_launch) begin
        if (!kp.busy_i) begin
          e_start = 1; m_launch = 0; m_operand = 0;
        end
      end else if (kv) begin
        if (kc <= 4'd9) begin
          if (m_digits == 0)      begin e_load_d = 1; m_tecla = kc; m_digits = 1; end
          else if (m_digits == 1) begin e_load_u = 1; m_tecla = kc; m_digits = 2; end
          else e_err = 1;
        end else if (kc == 4'hE) begin
          if (m_digits != 0) begin m_digits = 0; m_operand = 0; end
        end else if (kc == 4'hF) begin
          if (m_digits == 2) begin
            e_rdy = 1; m_digits = 0;
            if (m_operand) m_launch = 1;
            else m_operand = 1;
          end else if (m_digits == 1) e_err = 1;
        end else e_err = 1;
      end
      if (!active || kv) m_idle = 0;
      else if (m_idle == T - 1) begin
        e_timeout = 1; m_digits = 0; m_operand = 0; m_idle = 0;
      end else m_idle++;
    end
  end

  // scoreboard: every cycle out of reset, DUT outputs against the model
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      logic [10:0] act, exp;
      act = {kp.load_d, kp.load_u, kp.rdy, kp.start, kp.timeout, dut_err, kp.op_sel, kp.tecla_d};
      exp = {e_load_d, e_load_u, e_rdy, e_start, e_timeout, (ERR_ON ? e_err : 1'b0), m_operand, m_tecla};
      vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("FAIL cycle_model t=%0t: got ld=%b lu=%b rdy=%b st=%b to=%b err=%b op=%b d=%0h, expected ld=%b lu=%b rdy=%b st=%b to=%b err=%b op=%b d=%0h",
                 $time, act[10], act[9], act[8], act[7], act[6], act[5], act[4], act[3:0],
                 exp[10], exp[9], exp[8], exp[7], exp[6], exp[5], exp[4], exp[3:0]);
      end
    end
  end

  // driver tasks
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic press(input logic [3:0] code);
    kp.key_valid = 1'b1;
    kp.key_code  = code;
    @(negedge clk);
    kp.key_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    kp.key_valid = 1'b0;
    kp.key_code  = 4'd0;
    kp.busy_i    = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {5'd0, kp.load_d, kp.load_u, kp.rdy, kp.start, kp.timeout, kp.op_sel, kp.tecla_d}, 16'h0);
    chk("reset_err", dut_err, 0);
    rst = 1'b1;
    @(negedge clk);

    // operand A = 42, operand B = 07, downstream idle
    press(4'd4); chk("a_tens", {kp.load_d, kp.tecla_d}, {1'b1, 4'd4});
    press(4'd2); chk("a_units", {kp.load_u, kp.tecla_d}, {1'b1, 4'd2});
    press(4'hF); chk("a_rdy", {kp.rdy, kp.op_sel}, 2'b11);
    press(4'd0); chk("b_tens", {kp.load_d, kp.tecla_d}, {1'b1, 4'd0});
    press(4'd7); chk("b_units", {kp.load_u, kp.tecla_d}, {1'b1, 4'd7});
    press(4'hF); chk("b_rdy", {kp.rdy, kp.start}, 2'b10);
    @(negedge clk); chk("start_pulse", {kp.start, kp.op_sel}, 2'b10);

    // full entry while downstream busy; keys during the hold are ignored
    kp.busy_i = 1'b1;
    press(4'd1); press(4'd2); press(4'hF);
    press(4'd3); press(4'd4); press(4'hF);
    for (int i = 0; i < 10; i++) begin
      press(4'(i));
      chk("busy_hold", {kp.load_d, kp.load_u, kp.rdy, kp.start}, 4'b0000);
    end
    kp.busy_i = 1'b0;
    @(negedge clk); chk("start_after_busy", {kp.start, kp.op_sel}, 2'b10);

    // inactivity timeout
    press(4'd5);
    idle(T - 1); chk("no_early_timeout", kp.timeout, 0);
    idle(1);     chk("timeout_pulse", {kp.timeout, kp.op_sel}, 2'b10);
    press(4'd3); chk("after_timeout", {kp.load_d, kp.tecla_d, kp.op_sel}, {1'b1, 4'd3, 1'b0});

    // key on the expiry cycle wins
    idle(T - 1);
    press(4'd6); chk("key_wins_expiry", {kp.load_u, kp.timeout, kp.tecla_d}, {1'b1, 1'b0, 4'd6});

    // clear, then 9,* then 1,6,#
    press(4'hE); chk("clear_no_strobe", {kp.load_d, kp.load_u, kp.rdy}, 3'b000);
    press(4'd9); chk("nine_tens", {kp.load_d, kp.tecla_d}, {1'b1, 4'd9});
    press(4'hE); chk("star_no_strobe", {kp.load_d, kp.load_u, kp.rdy, kp.tecla_d}, {3'b000, 4'd9});
    press(4'd1); chk("one_tens", {kp.load_d, kp.tecla_d}, {1'b1, 4'd1});
    press(4'd6); chk("six_units", {kp.load_u, kp.tecla_d, kp.op_sel}, {1'b1, 4'd6, 1'b0});
    press(4'hF); chk("rdy_after_clear", {kp.rdy, kp.op_sel}, 2'b11);

    // error events: 8,# then 3,3
    press(4'd8); chk("eight_tens", {kp.load_d, kp.tecla_d}, {1'b1, 4'd8});
    press(4'hF); chk("early_enter", kp.rdy, 0);
    chk("early_enter_err", dut_err, ERR_ON);
    press(4'd3); chk("three_units", {kp.load_u, kp.tecla_d}, {1'b1, 4'd3});
    press(4'd3); chk("extra_digit", {kp.load_u, dut_err}, {1'b0, ERR_ON});
    press(4'hF); chk("b2_rdy", kp.rdy, 1);
    @(negedge clk); chk("b2_start", kp.start, 1);
    press(4'hA); chk("code_a", {kp.load_d, dut_err}, {1'b0, ERR_ON});

    // async reset cuts a strobe in flight
    press(4'd4); chk("pre_reset_strobe", kp.load_d, 1);
    #2 rst = 1'b0;
    #1 chk("reset_cuts", {kp.load_d, kp.op_sel, kp.tecla_d}, 6'd0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);

    // random stretch checked by the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) idle($urandom_range(15, 25));
      kp.busy_i = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 2) == 0) press(4'($urandom_range(0, 15)));
      else idle(1);
    end
    kp.busy_i = 1'b0;
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
